// File: rtl/dcm_pkg.sv
// Shared types and constants for the clock-manager frequency meter.
package dcm_pkg;

    localparam int PROG_W    = 3;
    localparam int NUM_CODES = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DECODE  = 2'd2
    } state_e;

    // Nominal period (in system-clock cycles) produced by program code k.
    function automatic logic [31:0] expected_period(input int k, input int base);
        return 32'(base) << k;
    endfunction

endpackage

// File: rtl/dcm_edge_sync.sv
// Two-flop synchroniser for an asynchronous clock plus a rising-edge pulse.
module dcm_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q, dly_d;

    // Next values of the synchroniser chain and the edge-detect register.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Chain registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/dcm_freq_meter.sv
// Measures the period of clk_meas in system-clock cycles and decodes it back
// to the 3-bit program code that generated it; tracks lock and errors.
module dcm_freq_meter
    import dcm_pkg::*;
#(
    parameter int BASE_PERIOD = 2,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 2,
    parameter int TIMEOUT     = 4096,
    parameter int CW          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clk_meas,
    input  logic              enable,
    output logic [CW-1:0]     period_out,
    output logic [PROG_W-1:0] prog_detect,
    output logic              meas_valid,
    output logic              locked,
    output logic              code_changed,
    output logic              error
);

    localparam int CW1 = CW + 1;
    localparam int MW  = $clog2(LOCK_CNT + 1);

    logic rise;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     per_q, per_d;
    logic [CW-1:0]     period_out_q, period_out_d;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic [PROG_W-1:0] lock_code_q, lock_code_d;
    logic [MW-1:0]     match_q, match_d;
    logic              lock_seen_q, lock_seen_d;
    logic              meas_valid_q, meas_valid_d;
    logic              locked_q, locked_d;
    logic              cc_q, cc_d;
    logic              error_q, error_d;

    logic              hit;
    logic [PROG_W-1:0] hit_code;
    logic [CW1-1:0]    exp_v, per_v, diff_v;

    dcm_edge_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (clk_meas),
        .rise  (rise)
    );

    // Match the latched period against every code; descending scan so the
    // lowest matching code is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        exp_v    = '0;
        diff_v   = '0;
        per_v    = {1'b0, per_q};
        for (int k = NUM_CODES - 1; k >= 0; k--) begin
            exp_v  = CW1'(expected_period(k, BASE_PERIOD));
            diff_v = (per_v >= exp_v) ? (per_v - exp_v) : (exp_v - per_v);
            if (diff_v <= CW1'(TOL)) begin
                hit      = 1'b1;
                hit_code = PROG_W'(k);
            end
        end
    end

    // Measurement FSM: next state, counters and result registers.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        per_d        = per_q;
        period_out_d = period_out_q;
        prog_d       = prog_q;
        lock_code_d  = lock_code_q;
        lock_seen_d  = lock_seen_q;
        match_d      = match_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        cc_d         = 1'b0;
        error_d      = error_q;

        if (!enable) begin
            // Abort quietly: results and status hold.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CW'(1);
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        per_d   = cnt_q;
                        cnt_d   = CW'(1);
                        state_d = DECODE;
                    end else if (cnt_q >= CW'(TIMEOUT)) begin
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                DECODE: begin
                    period_out_d = per_q;
                    meas_valid_d = 1'b1;
                    if (hit) begin
                        prog_d  = hit_code;
                        error_d = 1'b0;
                        if (hit_code == prog_q)
                            match_d = (match_q >= MW'(LOCK_CNT)) ? match_q : match_q + MW'(1);
                        else
                            match_d = MW'(1);
                        locked_d = (match_d >= MW'(LOCK_CNT));
                        // Report a change only on a fresh lock to a new code.
                        if (locked_d && !locked_q) begin
                            cc_d        = !lock_seen_q || (hit_code != lock_code_q);
                            lock_code_d = hit_code;
                            lock_seen_d = 1'b1;
                        end
                    end else begin
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                    end
                    // The cycle after the closing rise was already counted on
                    // entry; this DECODE cycle is the next one of the new
                    // period. A rise landing here restarts the count from it.
                    state_d = MEASURE;
                    cnt_d   = rise ? CW'(1) : cnt_q + CW'(1);
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            per_q        <= '0;
            period_out_q <= '0;
            prog_q       <= '0;
            lock_code_q  <= '0;
            lock_seen_q  <= 1'b0;
            match_q      <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            cc_q         <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            period_out_q <= period_out_d;
            prog_q       <= prog_d;
            lock_code_q  <= lock_code_d;
            lock_seen_q  <= lock_seen_d;
            match_q      <= match_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            cc_q         <= cc_d;
            error_q      <= error_d;
        end
    end

    assign period_out   = period_out_q;
    assign prog_detect  = prog_q;
    assign meas_valid   = meas_valid_q;
    assign locked       = locked_q;
    assign code_changed = cc_q;
    assign error        = error_q;

endmodule
